// File: rtl/philv_ctrl_exec.sv
// -----------------------------------------------------------------------------
// philv_ctrl_exec
//   Control/execute unit of the Philosophy-V multi-cycle RV32I core. It holds
//   the main sequencing FSM, the instruction field/immediate decoder and the
//   combinational ALU. Every enable and mux select of the core comes from here.
//
// Configuration macro:
//   PHILV_ALU_SHIFT_EN - when defined, the ALU computes SLL/SRL/SRA.
//                        When undefined, no shifter is built and the shift
//                        function codes return 0. FSM sequencing is the same
//                        in both builds.
//
// Ports:
//   clk, rstb            core clock; synchronous active-low reset
//   instr                instruction register contents
//   alu_x, alu_y         ALU operands from the A/B source muxes
//   alu_z, alu_zero      ALU result (combinational) and zero flag
//   rs1, rs2, rd         register fields of instr
//   immed                sign-extended I/S immediate (0 for other formats)
//   PCWrite, IRWrite     PC enable; instruction fetch / IR enable
//   DMemWrite            data-memory write enable
//   regFileWrite         register-file write enable
//   ALUSrcA              0=PC, 1=rs1 data
//   ALUSrcB              00=rs2, 01=const 4, 10=immed
//   regFileWriteSrc      00=mem word, 01=ALU, 10=sext byte, 11=sext half
// -----------------------------------------------------------------------------
module philv_ctrl_exec #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [BUS_WIDTH-1:0] instr,
    input  logic [BUS_WIDTH-1:0] alu_x,
    input  logic [BUS_WIDTH-1:0] alu_y,
    output logic [BUS_WIDTH-1:0] alu_z,
    output logic                 alu_zero,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [BUS_WIDTH-1:0] immed,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 DMemWrite,
    output logic                 regFileWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           regFileWriteSrc
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SUB  = 4'b1000;
    localparam logic [3:0] F_SLL  = 4'b0001;
    localparam logic [3:0] F_SLT  = 4'b0010;
    localparam logic [3:0] F_SLTU = 4'b0011;
    localparam logic [3:0] F_XOR  = 4'b0100;
    localparam logic [3:0] F_SRL  = 4'b0101;
    localparam logic [3:0] F_SRA  = 4'b1101;
    localparam logic [3:0] F_OR   = 4'b0110;
    localparam logic [3:0] F_AND  = 4'b0111;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_imm, is_load, is_store, supported;
    logic [3:0] alu_funct;
    logic       pc_we, ir_we, dm_we, rf_we;

    // Field decode, re-evaluated every cycle from the (stable) IR.
    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign rd        = instr[11:7];
    assign is_r      = (opcode == OP_R);
    assign is_imm    = (opcode == OP_IMM);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign supported = is_r | is_imm | is_load | is_store;

    always_comb begin
        immed = '0;
        if (is_imm || is_load)
            immed = {{20{instr[31]}}, instr[31:20]};
        else if (is_store)
            immed = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    end

    always_ff @(posedge clk) begin
        if (!rstb) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        pc_we           = 1'b0;
        ir_we           = 1'b0;
        dm_we           = 1'b0;
        rf_we           = 1'b0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = 2'b00;
        regFileWriteSrc = 2'b00;
        alu_funct       = F_ADD;
        case (state)
            FETCH: begin
                ir_we     = 1'b1;
                ALUSrcB   = 2'b01;          // PC + 4
                state_nxt = DECODE;
            end
            DECODE: begin
                pc_we     = 1'b1;
                // Unsupported opcodes retire here as a NOP.
                state_nxt = supported ? EXECUTE : FETCH;
            end
            EXECUTE: begin
                ALUSrcA   = 1'b1;
                state_nxt = MEMORY;
                if (is_r) begin
                    alu_funct = {instr[30], funct3};
                end else if (is_imm) begin
                    // instr[30] is part of the immediate except for SRAI.
                    ALUSrcB   = 2'b10;
                    alu_funct = {instr[30] & (funct3 == 3'b101), funct3};
                end else begin
                    ALUSrcB   = 2'b10;      // load/store address = rs1 + imm
                end
            end
            MEMORY: begin
                if (is_store) begin
                    dm_we     = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = WRITEBACK;
                end
            end
            WRITEBACK: begin
                rf_we     = 1'b1;
                state_nxt = FETCH;
                if (is_r || is_imm)
                    regFileWriteSrc = 2'b01;
                else if (is_load) begin
                    case (funct3)
                        3'b000:  regFileWriteSrc = 2'b10;
                        3'b001:  regFileWriteSrc = 2'b11;
                        default: regFileWriteSrc = 2'b00;
                    endcase
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Write enables are held low for as long as reset is asserted, not only
    // from the first reset edge onward.
    assign PCWrite      = pc_we & rstb;
    assign IRWrite      = ir_we & rstb;
    assign DMemWrite    = dm_we & rstb;
    assign regFileWrite = rf_we & rstb;

    always_comb begin
        alu_z = '0;
        case (alu_funct)
            F_ADD:  alu_z = alu_x + alu_y;
            F_SUB:  alu_z = alu_x - alu_y;
            F_SLT:  alu_z = {{(BUS_WIDTH-1){1'b0}}, $signed(alu_x) < $signed(alu_y)};
            F_SLTU: alu_z = {{(BUS_WIDTH-1){1'b0}}, alu_x < alu_y};
            F_XOR:  alu_z = alu_x ^ alu_y;
            F_OR:   alu_z = alu_x | alu_y;
            F_AND:  alu_z = alu_x & alu_y;
`ifdef PHILV_ALU_SHIFT_EN
            F_SLL:  alu_z = alu_x << alu_y[4:0];
            F_SRL:  alu_z = alu_x >> alu_y[4:0];
            F_SRA:  alu_z = $unsigned($signed(alu_x) >>> alu_y[4:0]);
`else
            F_SLL, F_SRL, F_SRA: alu_z = '0;
`endif
            default: alu_z = '0;
        endcase
    end

    assign alu_zero = (alu_z == '0);

endmodule

// File: tb/tb_philv_ctrl_exec.sv
// -----------------------------------------------------------------------------
// tb_philv_ctrl_exec
//   Self-checking bench for philv_ctrl_exec. Directed instructions followed by
//   randomized ones; per-cycle expectations come from an instruction-level
//   model (cycle index within the instruction + RV32I semantics).
// -----------------------------------------------------------------------------
module tb_philv_ctrl_exec;

    logic        clk = 1'b0;
    logic        rstb;
    logic [31:0] instr, alu_x, alu_y, alu_z, immed;
    logic        alu_zero;
    logic [4:0]  rs1, rs2, rd;
    logic        PCWrite, IRWrite, DMemWrite, regFileWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, regFileWriteSrc;

    int n_cmp = 0;
    int n_err = 0;

    philv_ctrl_exec #(.BUS_WIDTH(32)) dut (
        .clk(clk), .rstb(rstb), .instr(instr), .alu_x(alu_x), .alu_y(alu_y),
        .alu_z(alu_z), .alu_zero(alu_zero), .rs1(rs1), .rs2(rs2), .rd(rd),
        .immed(immed), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .DMemWrite(DMemWrite), .regFileWrite(regFileWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .regFileWriteSrc(regFileWriteSrc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (instr %h)", tag, obs, exp, instr);
        end
    endtask

    function automatic int latency(input logic [31:0] i);
        case (i[6:0])
            7'h33, 7'h13, 7'h03: return 5;
            7'h23:               return 4;
            default:             return 2;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03: return {{20{i[31]}}, i[31:20]};
            7'h23:        return {{20{i[31]}}, i[31:25], i[11:7]};
            default:      return 32'h0;
        endcase
    endfunction

    // RV32I register/immediate arithmetic; alt is the "alternate" encoding bit.
    function automatic logic [31:0] rv_op(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        r = 32'h0;
        case (f3)
            3'd0: r = alt ? x - y : x + y;
            3'd2: r = alt ? 32'h0 : (($signed(x) < $signed(y)) ? 32'd1 : 32'd0);
            3'd3: r = alt ? 32'h0 : ((x < y) ? 32'd1 : 32'd0);
            3'd4: r = alt ? 32'h0 : x ^ y;
            3'd6: r = alt ? 32'h0 : x | y;
            3'd7: r = alt ? 32'h0 : x & y;
`ifdef PHILV_ALU_SHIFT_EN
            3'd1: r = alt ? 32'h0 : x << y[4:0];
            3'd5: r = alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
`else
            default: r = 32'h0;
`endif
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] i, input int k,
                                            input logic [31:0] x, input logic [31:0] y);
        if (k == 2 && i[6:0] == 7'h33) return rv_op(i[14:12], i[30], x, y);
        if (k == 2 && i[6:0] == 7'h13) return rv_op(i[14:12], i[30] && i[14:12] == 3'd5, x, y);
        return x + y;
    endfunction

    // {PCWrite,IRWrite,DMemWrite,regFileWrite,ALUSrcA,ALUSrcB,regFileWriteSrc}
    function automatic logic [8:0] ref_ctl(input logic [31:0] i, input int k);
        logic [1:0] src;
        case (k)
            0: return 9'b0_1_0_0_0_01_00;
            1: return 9'b1_0_0_0_0_00_00;
            2: return (i[6:0] == 7'h33) ? 9'b0_0_0_0_1_00_00 : 9'b0_0_0_0_1_10_00;
            3: return (i[6:0] == 7'h23) ? 9'b0_0_1_0_0_00_00 : 9'b0;
            default: begin
                if (i[6:0] == 7'h03)
                    src = (i[14:12] == 3'd0) ? 2'b10 : (i[14:12] == 3'd1) ? 2'b11 : 2'b00;
                else
                    src = 2'b01;
                return {7'b0_0_0_1_0_00, src};
            end
        endcase
    endfunction

    // Entered just after a rising edge with the DUT in FETCH; leaves the same way.
    task automatic run_instr(input logic [31:0] ins, input int abort_at);
        int lat;
        logic [8:0] ctl;
        instr = ins;
        lat = latency(ins);
        for (int k = 0; k < lat; k++) begin
            case ($urandom_range(0, 3))
                0: begin alu_x = $urandom; alu_y = alu_x; end
                1: begin alu_x = $urandom_range(0, 40); alu_y = $urandom_range(0, 40); end
                default: begin alu_x = $urandom; alu_y = $urandom; end
            endcase
            if (ins == 32'h402081B3 && k == 2) begin alu_x = 32'd5; alu_y = 32'd7; end
            if (k == abort_at) begin
                rstb = 1'b0;
                @(negedge clk);
                chk("we_in_reset", {28'h0, PCWrite, IRWrite, DMemWrite, regFileWrite}, 32'h0);
                @(posedge clk); #1;
                rstb = 1'b1;
                return;
            end
            @(negedge clk);
            ctl = ref_ctl(ins, k);
            chk($sformatf("ctl_c%0d", k),
                {23'h0, PCWrite, IRWrite, DMemWrite, regFileWrite, ALUSrcA, ALUSrcB, regFileWriteSrc},
                {23'h0, ctl});
            chk($sformatf("alu_z_c%0d", k), alu_z, ref_alu(ins, k, alu_x, alu_y));
            chk("alu_zero", {31'h0, alu_zero}, {31'h0, ref_alu(ins, k, alu_x, alu_y) == 32'h0});
            if (k == 0) begin
                chk("immed", immed, ref_imm(ins));
                chk("regs", {17'h0, rs1, rs2, rd}, {17'h0, ins[19:15], ins[24:20], ins[11:7]});
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 5))
            0: i[6:0] = 7'h33;
            1: i[6:0] = 7'h13;
            2: begin i[6:0] = 7'h03; if ($urandom_range(0, 1) == 1) i[14:12] = 3'($urandom_range(0, 2)); end
            3: i[6:0] = 7'h23;
            4: i[6:0] = 7'h33;
            default: i[6:0] = 7'($urandom);
        endcase
        return i;
    endfunction

    logic [31:0] directed [8] = '{32'h002081B3, 32'h402081B3, 32'hFFF00093, 32'h0020A423,
                                  32'h00008083, 32'h00009083, 32'h0000007F, 32'h4020D1B3};

    initial begin
        rstb  = 1'b0;
        instr = 32'h0;
        alu_x = 32'h0;
        alu_y = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_we", {28'h0, PCWrite, IRWrite, DMemWrite, regFileWrite}, 32'h0);
        @(posedge clk); #1;
        rstb = 1'b1;

        // SUB 5-7 in EXECUTE is forced inside run_instr for 0x402081B3.
        foreach (directed[n]) run_instr(directed[n], -1);

        for (int n = 0; n < 250; n++) begin
            if (n % 37 == 20) run_instr(rnd_instr(), int'($urandom_range(0, 1)) + 1);
            else              run_instr(rnd_instr(), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
